// File: rtl/nl2_cln_wrr_arbiter.sv
// Weighted round-robin arbiter with packet locking for the CLN NoC ports.
// Selection is combinational (zero-cycle req_valid -> out_valid); the state
// registers hold the round-robin pivot, the current owner, its remaining
// packet credit and the in-packet lock flag.
module nl2_cln_wrr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ),
  parameter int unsigned WGT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WGT_W-1:0] weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_REQ-1:0]       gnt_onehot,
  output logic [IDX_W-1:0]         gnt_idx,
  output logic                     gnt_last,
  output logic                     locked
);

  logic [IDX_W-1:0] pivot_q, pivot_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [WGT_W-1:0] credit_q, credit_d;
  logic             lock_q, lock_d;

  logic             hi_found, lo_found;
  logic [IDX_W-1:0] hi_idx, lo_idx, rr_idx;
  logic [IDX_W-1:0] cand;
  logic             sel_valid;
  logic [WGT_W-1:0] wsel, reload, newcredit;
  logic             xfer;

  // Circular priority search starting just above the pivot.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_valid[i]) begin
        if (IDX_W'(i) > pivot_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IDX_W'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    rr_idx = hi_found ? hi_idx : lo_idx;
  end

  // Candidate choice: locked owner, crediting owner, or round-robin winner.
  always_comb begin
    cand      = rr_idx;
    sel_valid = |req_valid;
    if (lock_q) begin
      cand      = owner_q;
      sel_valid = req_valid[owner_q];
    end else if ((credit_q != '0) && req_valid[owner_q]) begin
      cand = owner_q;
    end
    if (rst_a) begin
      sel_valid = 1'b0;
    end
  end

  // Grant outputs are forced to zero whenever nothing is selected.
  always_comb begin
    out_valid  = sel_valid;
    gnt_idx    = sel_valid ? cand : '0;
    gnt_onehot = sel_valid ? (NUM_REQ'(1) << cand) : '0;
    gnt_last   = sel_valid & req_last[cand];
    req_ready  = gnt_onehot & {NUM_REQ{out_ready}};
    locked     = lock_q;
  end

  // Next-state: lock tracking per beat, credit accounting per packet.
  always_comb begin
    pivot_d  = pivot_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    lock_d   = lock_q;
    xfer     = sel_valid & out_ready;
    wsel     = weight[int'(cand)*int'(WGT_W) +: WGT_W];
    reload   = (wsel == '0) ? '0 : wsel - WGT_W'(1);
    newcredit = ((cand == owner_q) && (credit_q != '0)) ? credit_q - WGT_W'(1) : reload;
    if (xfer) begin
      owner_d = cand;
      if (!gnt_last) begin
        lock_d = 1'b1;
      end else begin
        lock_d   = 1'b0;
        credit_d = newcredit;
        if (newcredit == '0) begin
          pivot_d = cand;
        end
      end
    end
  end

  // State register; reset gives requester 0 top priority.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      pivot_q  <= IDX_W'(NUM_REQ - 1);
      owner_q  <= '0;
      credit_q <= '0;
      lock_q   <= 1'b0;
    end else begin
      pivot_q  <= pivot_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      lock_q   <= lock_d;
    end
  end

endmodule

// File: tb/tb_nl2_cln_wrr_arbiter.sv
// Directed bench for the weighted round-robin arbiter.
module tb_nl2_cln_wrr_arbiter;

  logic        clk;
  logic        rst_a;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [15:0] weight;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  gnt_onehot;
  logic [1:0]  gnt_idx;
  logic        gnt_last;
  logic        locked;

  int checks = 0;
  int errors = 0;

  nl2_cln_wrr_arbiter #(.NUM_REQ(4), .IDX_W(2), .WGT_W(4)) dut (
    .clk(clk), .rst_a(rst_a), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .weight(weight), .out_valid(out_valid),
    .out_ready(out_ready), .gnt_onehot(gnt_onehot), .gnt_idx(gnt_idx),
    .gnt_last(gnt_last), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs at the falling edge and let combinational outputs settle.
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic r);
    @(negedge clk);
    req_valid = v;
    req_last  = l;
    out_ready = r;
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_last  = '0;
    out_ready = 1'b0;
    rst_a     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    weight = 16'h1111;
    rst_a = 1'b1;
    req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || gnt_onehot !== 4'b0 || gnt_idx !== 2'd0 || locked !== 1'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b oh=%b idx=%0d lk=%b rdy=%b, want all zero",
               out_valid, gnt_onehot, gnt_idx, locked, req_ready);
    end
    rst_a = 1'b0;
    #1;
    checks++;
    if (gnt_onehot !== 4'b0001 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: got oh=%b v=%b, want 0001 1", gnt_onehot, out_valid);
    end
  endtask

  task automatic test_round_robin();
    int exp_idx[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    weight = 16'h1111;
    for (int c = 0; c < 8; c++) begin
      step(4'b1111, 4'b1111, 1'b1);
      checks++;
      if (gnt_idx !== 2'(exp_idx[c]) || req_ready !== (4'b0001 << exp_idx[c])) begin
        errors++;
        $display("FAIL rr_seq cyc%0d: got idx=%0d rdy=%b, want idx=%0d", c, gnt_idx, req_ready, exp_idx[c]);
      end
    end
  endtask

  task automatic test_idle();
    step(4'b0000, 4'b1111, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || gnt_onehot !== 4'b0 || gnt_idx !== 2'd0 || gnt_last !== 1'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL idle_zero: got v=%b oh=%b idx=%0d last=%b rdy=%b, want zeros",
               out_valid, gnt_onehot, gnt_idx, gnt_last, req_ready);
    end
    // pivot held at 3 from the previous sequence, so requester 0 is next
    step(4'b1111, 4'b1111, 1'b1);
    checks++;
    if (gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL idle_hold: got idx=%0d, want 0", gnt_idx);
    end
  endtask

  task automatic test_weighted();
    int exp_idx[10] = '{0, 0, 0, 1, 2, 3, 3, 0, 0, 0};
    do_reset();
    weight = {4'd2, 4'd1, 4'd1, 4'd3};
    for (int c = 0; c < 10; c++) begin
      step(4'b1111, 4'b1111, 1'b1);
      checks++;
      if (gnt_idx !== 2'(exp_idx[c])) begin
        errors++;
        $display("FAIL wrr_seq cyc%0d: got idx=%0d, want %0d", c, gnt_idx, exp_idx[c]);
      end
    end
  endtask

  task automatic test_zero_weight();
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    do_reset();
    weight = 16'h0000;
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, 4'b1111, 1'b1);
      checks++;
      if (gnt_idx !== 2'(exp_idx[c])) begin
        errors++;
        $display("FAIL zero_wgt cyc%0d: got idx=%0d, want %0d", c, gnt_idx, exp_idx[c]);
      end
    end
  endtask

  task automatic test_locked_packet();
    int rdy[6]  = '{1, 0, 1, 1, 0, 1};
    int lk[6]   = '{0, 1, 1, 1, 1, 1};
    logic [3:0] last;
    do_reset();
    weight = 16'h1111;
    step(4'b0111, 4'b0101, 1'b1);  // req0 single beat moves pivot to 0
    checks++;
    if (gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL lock_pre: got idx=%0d, want 0", gnt_idx);
    end
    for (int c = 0; c < 6; c++) begin
      last = (c < 4) ? 4'b0101 : 4'b0111;
      step(4'b0111, last, rdy[c][0]);
      checks++;
      if (gnt_idx !== 2'd1 || locked !== lk[c][0] || out_valid !== 1'b1 ||
          req_ready !== (rdy[c][0] ? 4'b0010 : 4'b0000) || gnt_last !== last[1]) begin
        errors++;
        $display("FAIL lock_beat cyc%0d: got idx=%0d lk=%b rdy=%b last=%b, want idx=1 lk=%0d",
                 c, gnt_idx, locked, req_ready, gnt_last, lk[c]);
      end
    end
    step(4'b0111, 4'b0101, 1'b1);
    checks++;
    if (gnt_idx !== 2'd2 || locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_after: got idx=%0d lk=%b, want 2 0", gnt_idx, locked);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    weight = 16'h1111;
    step(4'b0100, 4'b0000, 1'b1);
    checks++;
    if (gnt_idx !== 2'd2) begin
      errors++;
      $display("FAIL bubble_start: got idx=%0d, want 2", gnt_idx);
    end
    for (int c = 0; c < 3; c++) begin
      step(4'b0001, 4'b0001, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || req_ready !== 4'b0 || gnt_onehot !== 4'b0 || locked !== 1'b1) begin
        errors++;
        $display("FAIL bubble_gap cyc%0d: got v=%b rdy=%b oh=%b lk=%b, want 0 0000 0000 1",
                 c, out_valid, req_ready, gnt_onehot, locked);
      end
    end
    step(4'b0101, 4'b0101, 1'b1);
    checks++;
    if (gnt_idx !== 2'd2 || gnt_last !== 1'b1 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bubble_resume: got idx=%0d last=%b rdy=%b, want 2 1 0100", gnt_idx, gnt_last, req_ready);
    end
    step(4'b0101, 4'b0101, 1'b1);
    checks++;
    if (gnt_idx !== 2'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL bubble_after: got idx=%0d lk=%b, want 0 0", gnt_idx, locked);
    end
  endtask

  task automatic test_forfeit();
    logic [3:0] v[5]  = '{4'b0001, 4'b1000, 4'b1001, 4'b1001, 4'b1001};
    int exp_idx[5]    = '{0, 3, 3, 0, 0};
    do_reset();
    weight = {4'd2, 4'd1, 4'd1, 4'd4};
    for (int c = 0; c < 5; c++) begin
      step(v[c], 4'b1111, 1'b1);
      checks++;
      if (gnt_idx !== 2'(exp_idx[c])) begin
        errors++;
        $display("FAIL forfeit cyc%0d: got idx=%0d, want %0d", c, gnt_idx, exp_idx[c]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    weight = 16'h1111;
    step(4'b0010, 4'b0000, 1'b1);
    step(4'b0010, 4'b0000, 1'b0);
    checks++;
    if (locked !== 1'b1 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL mid_lock: got lk=%b idx=%0d, want 1 1", locked, gnt_idx);
    end
    @(negedge clk);
    req_valid = 4'b1111;
    rst_a = 1'b1;
    #1;
    checks++;
    if (locked !== 1'b0 || gnt_onehot !== 4'b0 || gnt_idx !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got lk=%b oh=%b idx=%0d v=%b, want 0 0000 0 0",
               locked, gnt_onehot, gnt_idx, out_valid);
    end
    @(posedge clk);
    step(4'b0110, 4'b0110, 1'b1);
    rst_a = 1'b0;
    #1;
    checks++;
    if (gnt_idx !== 2'd1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: got idx=%0d lk=%b, want 1 0", gnt_idx, locked);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    req_valid = '0;
    req_last = '0;
    out_ready = 1'b0;
    weight = 16'h1111;
    test_reset();
    test_round_robin();
    test_idle();
    test_weighted();
    test_zero_weight();
    test_locked_packet();
    test_bubble();
    test_forfeit();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
